// File: rtl/clock_enable_ctrl.sv
// Per-engine clock-enable sequencer: OFF -> WAKE (settle) -> ON -> idle timeout -> OFF.
// en/ack/all_off come straight from flops so the downstream clock mux sees no glitches.
module clock_enable_ctrl #(
  parameter int unsigned N_CH         = 3,
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] en,
  output logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] err,
  output logic            all_off
);

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2
  } state_e;

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  en_q, en_d;
  logic [N_CH-1:0]  ack_q, ack_d;
  logic [N_CH-1:0]  err_q, err_d;
  logic             all_off_q, all_off_d;

  // State, counters and output flops
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      en_q      <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      all_off_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q      <= en_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      all_off_q <= all_off_d;
    end
  end

  // Next state per channel; outputs are registered from the next state
  always_comb begin
    en_d      = '0;
    ack_d     = '0;
    err_d     = err_q;
    all_off_d = 1'b1;
    for (int i = 0; i < int'(N_CH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_OFF: begin
          if (busy[i]) err_d[i] = 1'b1;
          if (req[i]) begin
            state_d[i] = S_WAKE;
            cnt_d[i]   = '0;
          end
        end
        S_WAKE: begin
          if (cnt_q[i] == WAKE_LAST) begin
            state_d[i] = S_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        S_ON: begin
          // Activity on the timeout cycle keeps the channel on
          if (req[i] || busy[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == IDLE_LAST) begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = S_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      en_d[i]   = (state_d[i] != S_OFF);
      ack_d[i]  = (state_d[i] == S_ON);
      all_off_d = all_off_d & (state_d[i] == S_OFF);
    end
  end

  assign en      = en_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign all_off = all_off_q;

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Bench for clock_enable_ctrl: timestamp-based channel model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clock_enable_ctrl;

  localparam int N    = 3;
  localparam int WAKE = 4;
  localparam int IDLE = 16;

  logic         clk_in;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] busy;
  logic [N-1:0] en;
  logic [N-1:0] ack;
  logic [N-1:0] err;
  logic         all_off;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;

  clock_enable_ctrl #(
    .N_CH(N), .WAKE_CYCLES(WAKE), .IDLE_TIMEOUT(IDLE), .CNT_W(5)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .req    (req),
    .busy   (busy),
    .en     (en),
    .ack    (ack),
    .err    (err),
    .all_off(all_off)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Model: each channel is "on" from its request edge; ack arrives WAKE edges later;
  // it turns off once IDLE edges have passed since the later of ack or last activity.
  int t;
  bit m_on     [N];
  int m_ack_at [N];
  int m_last   [N];
  bit m_err    [N];

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      t = 0;
      for (int i = 0; i < N; i++) begin
        m_on[i] = 0; m_ack_at[i] = 0; m_last[i] = 0; m_err[i] = 0;
      end
    end else begin
      t = t + 1;
      for (int i = 0; i < N; i++) begin
        if (!m_on[i]) begin
          if (busy[i]) m_err[i] = 1;
          if (req[i]) begin
            m_on[i]     = 1;
            m_ack_at[i] = t + WAKE;
            m_last[i]   = t + WAKE;
          end
        end else if (t > m_ack_at[i]) begin
          if (req[i] || busy[i]) m_last[i] = t;
          else if (t - m_last[i] >= IDLE) m_on[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_in) begin
    if (chk_on) begin
      logic [N-1:0] e_en, e_ack, e_err;
      logic         e_off;
      e_off = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_en[i]  = m_on[i];
        e_ack[i] = m_on[i] && (t >= m_ack_at[i]);
        e_err[i] = m_err[i];
        if (m_on[i]) e_off = 1'b0;
      end
      chk("model_en",      32'(en),      32'(e_en));
      chk("model_ack",     32'(ack),     32'(e_ack));
      chk("model_err",     32'(err),     32'(e_err));
      chk("model_all_off", 32'(all_off), 32'(e_off));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    reset_n = 1'b1;
    req     = '0;
    busy    = '0;
    #1 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    chk_on  = 1;
    tick(1);
    // 1: reset state
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_all_off", 32'(all_off), 32'h1);

    // 2: single-cycle request on FIR
    req = 3'b001;
    tick(1);
    req = '0;
    chk("t2_en_after_E", 32'(en), 32'h1);
    chk("t2_ack_after_E", 32'(ack), 32'h0);
    chk("t2_all_off_E", 32'(all_off), 32'h0);
    tick(3);
    chk("t2_ack_E3", 32'(ack), 32'h0);
    tick(1);
    chk("t2_ack_E4", 32'(ack), 32'h1);
    tick(15);
    chk("t2_en_idle15", 32'(en), 32'h1);
    tick(1);
    chk("t2_en_idle16", 32'(en), 32'h0);
    chk("t2_ack_idle16", 32'(ack), 32'h0);
    chk("t2_all_off", 32'(all_off), 32'h1);

    // 3: busy holds FFT on; off 16 cycles after busy drops
    req = 3'b010;
    tick(1);
    req = '0;
    tick(4);
    chk("t3_ack", 32'(ack), 32'h2);
    busy = 3'b010;
    tick(40);
    chk("t3_en_busy", 32'(en), 32'h2);
    busy = '0;
    tick(15);
    chk("t3_en_15", 32'(en), 32'h2);
    tick(1);
    chk("t3_en_16", 32'(en), 32'h0);

    // 4: request on the timeout cycle keeps DMA on
    req = 3'b100;
    tick(1);
    req = '0;
    tick(4);
    tick(15);
    req = 3'b100;
    tick(1);
    req = '0;
    chk("t4_en_kept", 32'(en), 32'h4);
    tick(15);
    chk("t4_en_15", 32'(en), 32'h4);
    tick(1);
    chk("t4_en_16", 32'(en), 32'h0);

    // 5: busy while OFF sets sticky err
    busy = 3'b100;
    tick(1);
    busy = '0;
    chk("t5_err", 32'(err), 32'h4);
    chk("t5_en", 32'(en), 32'h0);
    tick(2);
    chk("t5_err_sticky", 32'(err), 32'h4);

    // 6: async reset during WAKE
    req = 3'b111;
    tick(1);
    req = '0;
    chk("t6_en_wake", 32'(en), 32'h7);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_en_rst", 32'(en), 32'h0);
    chk("t6_ack_rst", 32'(ack), 32'h0);
    chk("t6_err_rst", 32'(err), 32'h0);
    chk("t6_all_off_rst", 32'(all_off), 32'h1);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("t6_en_after", 32'(en), 32'h0);

    // Randomized traffic with one asynchronous reset mid-way
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 24) == 0);
        busy[i] = ($urandom_range(0, 40) == 0) || (en[i] && $urandom_range(0, 3) == 0 && c % 200 < 60);
      end
      if (c == 1500) begin
        #3 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      tick(1);
    end
    req  = '0;
    busy = '0;
    tick(40);
    chk("final_all_off", 32'(all_off), 32'h1);
    #1;
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
